// File: rtl/ucie_ctl_tx_buffer.sv
// UCIe adapter TX buffer: FDI flit FIFO toward RDI with link-state gating and drain.
// Optional per-byte even parity storage enabled by UCIE_CTL_TX_PARITY_EN.
module ucie_ctl_tx_buffer #(
    parameter int          NBYTES      = 8,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          AFULL_TH    = 6,
    parameter logic [3:0]  ACTIVE_CODE = 4'b0001,
    parameter int          CNT_W       = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [3:0]                    i_fdi_pl_state_sts,
    input  logic                          i_fdi_lp_valid,
    input  logic                          i_fdi_lp_irdy,
    input  logic [NBYTES*8-1:0]           i_fdi_lp_data,
    input  logic                          i_rdi_pl_trdy,
    input  logic                          i_err_clr,
    output logic                          o_fdi_pl_trdy,
    output logic                          o_rdi_lp_valid,
    output logic                          o_rdi_lp_irdy,
    output logic [NBYTES*8-1:0]           o_rdi_lp_data,
`ifdef UCIE_CTL_TX_PARITY_EN
    output logic [NBYTES-1:0]             o_rdi_lp_parity,
`endif
    output logic                          o_tx_overf_err,
    output logic [CNT_W-1:0]              o_drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int DW = NBYTES * 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
`ifdef UCIE_CTL_TX_PARITY_EN
    localparam int MW = DW + NBYTES;
`else
    localparam int MW = DW;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [MW-1:0]    r_mem [FIFO_DEPTH];
    logic             r_err;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_sts_act;
    logic             w_act;
    logic             w_xmit;
    logic             w_nempty;
    logic             w_full;
    logic             w_valid;
    logic             w_pop;
    logic             w_wr_try;
    logic             w_push;
    logic             w_ovf;
    logic [MW-1:0]    w_wr_word;
    logic [MW-1:0]    w_head;

    assign w_sts_act = (i_fdi_pl_state_sts == ACTIVE_CODE);
    assign w_act     = (r_state == S_ACTIVE);
    assign w_xmit    = (r_state == S_ACTIVE) || (r_state == S_DRAIN);
    assign w_nempty  = (r_level != '0);
    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_valid   = w_nempty && w_xmit;
    assign w_pop     = w_valid && i_rdi_pl_trdy;
    // Senders may ignore trdy, so acceptance depends only on real space.
    assign w_wr_try  = i_fdi_lp_valid && i_fdi_lp_irdy && w_act;
    assign w_push    = w_wr_try && (!w_full || w_pop);
    assign w_ovf     = w_wr_try && w_full && !w_pop;

`ifdef UCIE_CTL_TX_PARITY_EN
    logic [NBYTES-1:0] w_par;
    always_comb begin
        w_par = '0;
        for (int b = 0; b < NBYTES; b++) begin
            w_par[b] = ^i_fdi_lp_data[b*8 +: 8];
        end
    end
    assign w_wr_word = {w_par, i_fdi_lp_data};
`else
    assign w_wr_word = i_fdi_lp_data;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sts_act) w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!w_sts_act) w_state_nxt = w_nempty ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (w_sts_act)
                    w_state_nxt = S_ACTIVE;
                else if (!w_nempty || (r_level == LW'(1) && w_pop))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is not reset; the level gate hides stale entries.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_word;
    end

    // A fresh overflow takes priority over a coincident clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_ovf) begin
            r_err <= 1'b1;
            if (i_err_clr)
                r_drop_cnt <= CNT_W'(1);
            else if (!(&r_drop_cnt))
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end else if (i_err_clr) begin
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign w_head         = w_nempty ? r_mem[r_rd_ptr] : '0;
    assign o_fdi_pl_trdy  = w_act && (r_level < LW'(AFULL_TH));
    assign o_rdi_lp_valid = w_valid;
    assign o_rdi_lp_irdy  = w_valid;
    assign o_rdi_lp_data  = w_head[DW-1:0];
`ifdef UCIE_CTL_TX_PARITY_EN
    assign o_rdi_lp_parity = w_head[MW-1:DW];
`endif
    assign o_tx_overf_err = r_err;
    assign o_drop_cnt     = r_drop_cnt;
    assign o_fifo_level   = r_level;

endmodule

// File: tb/tb_ucie_ctl_tx_buffer.sv
// Directed bench for ucie_ctl_tx_buffer with an RDI-side scoreboard.
// Parity checks are compiled in with UCIE_CTL_TX_PARITY_EN.
module tb_ucie_ctl_tx_buffer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sts;
    logic        f_valid;
    logic        f_irdy;
    logic [63:0] f_data;
    logic        r_trdy;
    logic        err_clr;
    logic        f_trdy;
    logic        r_valid;
    logic        r_irdy;
    logic [63:0] r_data;
    logic        ovf;
    logic [15:0] drop;
    logic [3:0]  level;
`ifdef UCIE_CTL_TX_PARITY_EN
    logic [7:0]  par;
`endif

    int tests = 0;
    int fails = 0;
    logic [63:0] q[$];

    ucie_ctl_tx_buffer dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_fdi_pl_state_sts (sts),
        .i_fdi_lp_valid     (f_valid),
        .i_fdi_lp_irdy      (f_irdy),
        .i_fdi_lp_data      (f_data),
        .i_rdi_pl_trdy      (r_trdy),
        .i_err_clr          (err_clr),
        .o_fdi_pl_trdy      (f_trdy),
        .o_rdi_lp_valid     (r_valid),
        .o_rdi_lp_irdy      (r_irdy),
        .o_rdi_lp_data      (r_data),
`ifdef UCIE_CTL_TX_PARITY_EN
        .o_rdi_lp_parity    (par),
`endif
        .o_tx_overf_err     (ovf),
        .o_drop_cnt         (drop),
        .o_fifo_level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] d, input bit expect_acc);
        f_valid = 1'b1;
        f_irdy  = 1'b1;
        f_data  = d;
        if (expect_acc) q.push_back(d);
    endtask

    // Pop happens at the next posedge whenever valid&&trdy at the negedge.
    always @(negedge clk) begin
        if (rst_n && r_valid && r_trdy) begin
            if (q.size() == 0) begin
                chk("rdi_unexpected_pop", r_data, 64'hx);
            end else begin
                chk("rdi_data", r_data, q.pop_front());
                chk("rdi_irdy", {63'd0, r_irdy}, 64'd1);
            end
        end
    end

    initial begin
        rst_n = 1'b0; sts = 4'h0; f_valid = 1'b0; f_irdy = 1'b0;
        f_data = '0; r_trdy = 1'b0; err_clr = 1'b0;
        #2;
        chk("rst_trdy", {63'd0, f_trdy}, 64'd0);
        chk("rst_valid", {63'd0, r_valid}, 64'd0);
        chk("rst_data", r_data, 64'd0);
        chk("rst_level", {60'd0, level}, 64'd0);
        chk("rst_err", {63'd0, ovf}, 64'd0);
        chk("rst_drop", {48'd0, drop}, 64'd0);
`ifdef UCIE_CTL_TX_PARITY_EN
        chk("rst_par", {56'd0, par}, 64'd0);
`endif
        step();
        rst_n = 1'b1;
        sts = 4'b0001;
        step();
        chk("idle_to_active_trdy", {63'd0, f_trdy}, 64'd1);

        // Reset mid-burst
        for (int i = 1; i <= 3; i++) begin
            wr(64'(i), 1'b1);
            step();
        end
        chk("burst_level", {60'd0, level}, 64'd3);
        f_valid = 1'b0;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_level", {60'd0, level}, 64'd0);
        chk("arst_valid", {63'd0, r_valid}, 64'd0);
        chk("arst_data", r_data, 64'd0);
        chk("arst_trdy", {63'd0, f_trdy}, 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rel_level", {60'd0, level}, 64'd0);
        chk("rel_valid", {63'd0, r_valid}, 64'd0);
        step();

        // Ordering and latency
        r_trdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr(64'hA0 + 64'(i), 1'b1);
            step();
            chk("stream_level_le1", {63'd0, (level <= 4'd1)}, 64'd1);
            if (i == 0) begin
                chk("latency_valid", {63'd0, r_valid}, 64'd1);
                chk("latency_data", r_data, 64'hA0);
            end
        end
        f_valid = 1'b0;
        step();
        chk("stream_empty", {60'd0, level}, 64'd0);
        chk("stream_q", 64'(q.size()), 64'd0);

        // Throttle
        r_trdy = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            wr(64'h1000 + 64'(k), 1'b1);
            step();
            chk("thr_level", {60'd0, level}, 64'(k));
            chk("thr_trdy", {63'd0, f_trdy}, (k < 6) ? 64'd1 : 64'd0);
        end

        // Overflow: sender keeps pushing past trdy
        for (int k = 7; k <= 10; k++) begin
            wr(64'h1000 + 64'(k), k <= 8);
            step();
        end
        f_valid = 1'b0;
        chk("ovf_level", {60'd0, level}, 64'd8);
        chk("ovf_err", {63'd0, ovf}, 64'd1);
        chk("ovf_drop", {48'd0, drop}, 64'd2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err", {63'd0, ovf}, 64'd0);
        chk("clr_drop", {48'd0, drop}, 64'd0);
        chk("clr_level_kept", {60'd0, level}, 64'd8);
        wr(64'hBAD, 1'b0);
        err_clr = 1'b1;
        step();
        f_valid = 1'b0;
        chk("clr_ovf_err", {63'd0, ovf}, 64'd1);
        chk("clr_ovf_drop", {48'd0, drop}, 64'd1);
        step();
        err_clr = 1'b0;
        chk("clr2_drop", {48'd0, drop}, 64'd0);

        // Drain
        r_trdy = 1'b1;
        repeat (4) step();
        r_trdy = 1'b0;
        chk("pre_drain_level", {60'd0, level}, 64'd4);
        sts = 4'b0000;
        step();
        chk("drain_valid", {63'd0, r_valid}, 64'd1);
        chk("drain_trdy", {63'd0, f_trdy}, 64'd0);
        r_trdy = 1'b1;
        wr(64'hDEAD, 1'b0);
        repeat (4) step();
        chk("drain_level", {60'd0, level}, 64'd0);
        chk("drain_idle_valid", {63'd0, r_valid}, 64'd0);
        step();
        chk("idle_wr_level", {60'd0, level}, 64'd0);
        chk("idle_wr_err", {63'd0, ovf}, 64'd0);
        chk("idle_wr_drop", {48'd0, drop}, 64'd0);
        chk("drain_q", 64'(q.size()), 64'd0);

        // Re-entry from DRAIN
        f_valid = 1'b0;
        r_trdy = 1'b0;
        sts = 4'b0001;
        step();
        wr(64'h01, 1'b1);
        step();
`ifdef UCIE_CTL_TX_PARITY_EN
        chk("par_byte0", {56'd0, par}, 64'h01);
`endif
        wr(64'h0101, 1'b1); step();
        wr(64'h0703, 1'b1); step();
        wr(64'h0F0E, 1'b1); step();
        f_valid = 1'b0;
        sts = 4'b0000;
        step();
        r_trdy = 1'b1;
        step();
        step();
        chk("re_drain_level", {60'd0, level}, 64'd2);
        sts = 4'b0001;
        r_trdy = 1'b0;
        step();
        chk("re_trdy", {63'd0, f_trdy}, 64'd1);
        chk("re_level", {60'd0, level}, 64'd2);
        r_trdy = 1'b1;
        repeat (3) step();
        chk("re_empty", {60'd0, level}, 64'd0);
        chk("re_q", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
